// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the 5-stage MIPS32 pipeline.
//
// Sits between the ID/EX and EX/MEM registers. Produces logic, shift, move,
// arithmetic and multiply results, forwards pending HI/LO writes from MEM/WB,
// and runs MADD/MADDU/MSUB/MSUBU as a two-cycle operation.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   aluop_i, alusel_i         operation subtype / result class from ID/EX
//   wd_i, wreg_i              destination register address / write enable
//   reg1_i, reg2_i            source operands
//   hi_i, lo_i                architectural HI/LO
//   mem_whilo_i/_hi_i/_lo_i   HI/LO write pending in MEM
//   wb_whilo_i/_hi_i/_lo_i    HI/LO write pending in WB
//   ctrl_signal               stall vector; bit 4 means EX/MEM is held
//   wd_o, wreg_o, wdata_o     GPR write to EX/MEM
//   whilo_o, hi_o, lo_o       HI/LO write to EX/MEM
//   stallreq_o                stall request toward ctrl
// ---------------------------------------------------------------------------
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        mem_whilo_i,
  input  logic [31:0] mem_hi_i,
  input  logic [31:0] mem_lo_i,
  input  logic        wb_whilo_i,
  input  logic [31:0] wb_hi_i,
  input  logic [31:0] wb_lo_i,
  input  logic [5:0]  ctrl_signal,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
  localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_MUL_OP   = 8'b1010_1001;
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;
  localparam logic [2:0] RES_ARITH = 3'b100;
  localparam logic [2:0] RES_MUL   = 3'b101;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  // Signed overflow of a+b: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [DW-1:0] r);
    return (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
  endfunction

  // Signed overflow of a-b: operands differ in sign, result flips from a.
  function automatic logic sub_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [DW-1:0] r);
    return (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
  endfunction

  logic [0:0]        state_q, state_d;
  logic [2*DW-1:0]   prod_q, prod_d;

  logic [DW-1:0]     fwd_hi, fwd_lo;
  logic              hold;
  logic              is_madd, madd_signed, madd_neg;

  logic signed [2*DW-1:0] op1_sx, op2_sx, prod_s;
  logic [2*DW-1:0]        prod_u, madd_raw, madd_term, acc_sum;
  logic [DW-1:0]          sum, diff;
  logic signed [DW-1:0]   sra_res;

  logic [DW-1:0]     logic_res, shift_res, move_res, arith_res, mul_res, wdata_c;
  logic              wreg_c, whilo_c, stall_c;
  logic [DW-1:0]     hi_c, lo_c;

  logic              unused_ctrl;
  assign unused_ctrl = ^{ctrl_signal[5], ctrl_signal[3:0]};

  assign hold = ctrl_signal[4];

  // MEM holds the youngest pending HI/LO write, so it wins over WB.
  always_comb begin
    if (mem_whilo_i) begin
      fwd_hi = mem_hi_i;
      fwd_lo = mem_lo_i;
    end else if (wb_whilo_i) begin
      fwd_hi = wb_hi_i;
      fwd_lo = wb_lo_i;
    end else begin
      fwd_hi = hi_i;
      fwd_lo = lo_i;
    end
  end

  assign is_madd     = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP) ||
                       (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
  assign madd_signed = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MSUB_OP);
  assign madd_neg    = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);

  assign op1_sx    = {{DW{reg1_i[DW-1]}}, reg1_i};
  assign op2_sx    = {{DW{reg2_i[DW-1]}}, reg2_i};
  assign prod_s    = op1_sx * op2_sx;
  assign prod_u    = {{DW{1'b0}}, reg1_i} * {{DW{1'b0}}, reg2_i};
  assign madd_raw  = madd_signed ? $unsigned(prod_s) : prod_u;
  assign madd_term = madd_neg ? ({2*DW{1'b0}} - madd_raw) : madd_raw;
  assign acc_sum   = {fwd_hi, fwd_lo} + prod_q;

  assign sum     = reg1_i + reg2_i;
  assign diff    = reg1_i - reg2_i;
  assign sra_res = $signed(reg2_i) >>> reg1_i[4:0];

  // Per-class results; an aluop that does not belong to the class gives 0.
  always_comb begin
    logic_res = '0;
    shift_res = '0;
    move_res  = '0;
    arith_res = '0;
    mul_res   = '0;
    case (aluop_i)
      EXE_AND_OP:  logic_res = reg1_i & reg2_i;
      EXE_OR_OP:   logic_res = reg1_i | reg2_i;
      EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
      EXE_SLL_OP:  shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP:  shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP:  shift_res = sra_res;
      EXE_MFHI_OP: move_res  = fwd_hi;
      EXE_MFLO_OP: move_res  = fwd_lo;
      EXE_MOVZ_OP,
      EXE_MOVN_OP: move_res  = reg1_i;
      EXE_ADD_OP,
      EXE_ADDU_OP: arith_res = sum;
      EXE_SUB_OP,
      EXE_SUBU_OP: arith_res = diff;
      EXE_SLT_OP:  arith_res = {{(DW-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
      EXE_SLTU_OP: arith_res = {{(DW-1){1'b0}}, (reg1_i < reg2_i)};
      EXE_MUL_OP:  mul_res   = prod_s[DW-1:0];
      default: ;
    endcase

    case (alusel_i)
      RES_LOGIC: wdata_c = logic_res;
      RES_SHIFT: wdata_c = shift_res;
      RES_MOVE:  wdata_c = move_res;
      RES_ARITH: wdata_c = arith_res;
      RES_MUL:   wdata_c = mul_res;
      default:   wdata_c = '0;
    endcase
  end

  // Write-enable suppression, HI/LO write and the multiply-accumulate FSM.
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    wreg_c  = wreg_i;
    whilo_c = 1'b0;
    hi_c    = '0;
    lo_c    = '0;
    stall_c = 1'b0;

    case (aluop_i)
      EXE_ADD_OP:   if (add_ovf(reg1_i, reg2_i, sum))  wreg_c = 1'b0;
      EXE_SUB_OP:   if (sub_ovf(reg1_i, reg2_i, diff)) wreg_c = 1'b0;
      EXE_MOVZ_OP:  if (reg2_i != '0) wreg_c = 1'b0;
      EXE_MOVN_OP:  if (reg2_i == '0) wreg_c = 1'b0;
      EXE_MULT_OP,
      EXE_MULTU_OP: wreg_c = 1'b0;
      default: ;
    endcase

    if (is_madd) begin
      if (state_q == S_IDLE) begin
        // First cycle: capture the product and hold ID/EX for one more cycle.
        stall_c = 1'b1;
        if (!hold) begin
          state_d = S_ACC;
          prod_d  = madd_term;
        end
      end else begin
        // Second cycle: accumulate into the forwarded HI/LO seen now.
        whilo_c      = 1'b1;
        {hi_c, lo_c} = acc_sum;
        if (!hold) begin
          state_d = S_IDLE;
          prod_d  = '0;
        end
      end
    end else if (state_q == S_ACC) begin
      // Operation was flushed between its two cycles: drop the partial product.
      if (!hold) begin
        state_d = S_IDLE;
        prod_d  = '0;
      end
    end else begin
      case (aluop_i)
        EXE_MULT_OP: begin
          whilo_c      = 1'b1;
          {hi_c, lo_c} = prod_s;
        end
        EXE_MULTU_OP: begin
          whilo_c      = 1'b1;
          {hi_c, lo_c} = prod_u;
        end
        EXE_MTHI_OP: begin
          whilo_c = 1'b1;
          hi_c    = reg1_i;
          lo_c    = fwd_lo;
        end
        EXE_MTLO_OP: begin
          whilo_c = 1'b1;
          hi_c    = fwd_hi;
          lo_c    = reg1_i;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wd_o       = rst ? {RW{1'b0}} : wd_i;
    wreg_o     = rst ? 1'b0 : wreg_c;
    wdata_o    = rst ? {DW{1'b0}} : wdata_c;
    whilo_o    = rst ? 1'b0 : whilo_c;
    hi_o       = rst ? {DW{1'b0}} : hi_c;
    lo_o       = rst ? {DW{1'b0}} : lo_c;
    stallreq_o = rst ? 1'b0 : stall_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  localparam logic [7:0] NOP = 8'h00, AND_ = 8'h24, OR_ = 8'h25, XOR_ = 8'h26, NOR_ = 8'h27;
  localparam logic [7:0] SLL = 8'h7C, SRL = 8'h02, SRA = 8'h03;
  localparam logic [7:0] MOVZ = 8'h0A, MOVN = 8'h0B, MFHI = 8'h10, MTHI = 8'h11, MFLO = 8'h12, MTLO = 8'h13;
  localparam logic [7:0] SLT = 8'h2A, SLTU = 8'h2B, ADD = 8'h20, ADDU = 8'h21, SUB = 8'h22, SUBU = 8'h23;
  localparam logic [7:0] MULT = 8'h18, MULTU = 8'h19, MUL = 8'hA9;
  localparam logic [7:0] MADD = 8'hA6, MADDU = 8'hA8, MSUB = 8'hAA, MSUBU = 8'hAB;
  localparam logic [2:0] C_NOP = 3'd0, C_LOG = 3'd1, C_SHF = 3'd2, C_MOV = 3'd3, C_ARI = 3'd4, C_MUL = 3'd5;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
  logic        mem_whilo_i, wb_whilo_i;
  logic [31:0] mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
  logic [5:0]  ctrl_signal;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .hi_i(hi_i), .lo_i(lo_i),
    .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
    .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i), .ctrl_signal(ctrl_signal),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  // {aluop, alusel} pairs as the decoder would issue them.
  logic [10:0] op_tab [0:26] = '{
    {AND_, C_LOG}, {OR_, C_LOG}, {XOR_, C_LOG}, {NOR_, C_LOG},
    {SLL, C_SHF}, {SRL, C_SHF}, {SRA, C_SHF},
    {MOVZ, C_MOV}, {MOVN, C_MOV}, {MFHI, C_MOV}, {MFLO, C_MOV}, {MTHI, C_NOP}, {MTLO, C_NOP},
    {SLT, C_ARI}, {SLTU, C_ARI}, {ADD, C_ARI}, {ADDU, C_ARI}, {SUB, C_ARI}, {SUBU, C_ARI},
    {MULT, C_NOP}, {MULTU, C_NOP}, {MUL, C_MUL},
    {MADD, C_NOP}, {MADDU, C_NOP}, {MSUB, C_NOP}, {MSUBU, C_NOP}, {NOP, C_NOP}
  };

  function automatic logic is_mac(input logic [7:0] op);
    return op == MADD || op == MADDU || op == MSUB || op == MSUBU;
  endfunction

  function automatic logic [63:0] fwd_hilo();
    if (mem_whilo_i) return {mem_hi_i, mem_lo_i};
    if (wb_whilo_i)  return {wb_hi_i, wb_lo_i};
    return {hi_i, lo_i};
  endfunction

  // Behavioural model of a single-cycle op using 64-bit integer arithmetic.
  function automatic exp_t model(input logic [7:0] op, input logic [2:0] sel, input logic [4:0] wd,
                                 input logic we, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] hl);
    exp_t e;
    longint sa, sb, ua, ub, r;
    logic [63:0] r64;
    logic [31:0] v, low;
    logic [2:0] cls;
    e = '0;
    e.wd = wd;
    e.wreg = we;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    cls = C_NOP;
    v = '0;
    case (op)
      AND_: begin cls = C_LOG; v = a & b; end
      OR_:  begin cls = C_LOG; v = a | b; end
      XOR_: begin cls = C_LOG; v = a ^ b; end
      NOR_: begin cls = C_LOG; v = ~(a | b); end
      SLL:  begin cls = C_SHF; v = b << a[4:0]; end
      SRL:  begin cls = C_SHF; v = b >> a[4:0]; end
      SRA:  begin cls = C_SHF; r = sb >>> a[4:0]; r64 = r; v = r64[31:0]; end
      ADD, SUB: begin
        cls = C_ARI;
        r = (op == ADD) ? sa + sb : sa - sb;
        r64 = r;
        low = r64[31:0];
        v = low;
        if (longint'($signed(low)) != r) e.wreg = 1'b0;
      end
      ADDU: begin cls = C_ARI; r64 = ua + ub; v = r64[31:0]; end
      SUBU: begin cls = C_ARI; r64 = ua - ub; v = r64[31:0]; end
      SLT:  begin cls = C_ARI; v = (sa < sb) ? 32'd1 : 32'd0; end
      SLTU: begin cls = C_ARI; v = (ua < ub) ? 32'd1 : 32'd0; end
      MFHI: begin cls = C_MOV; v = hl[63:32]; end
      MFLO: begin cls = C_MOV; v = hl[31:0]; end
      MOVZ: begin cls = C_MOV; v = a; if (b != 0) e.wreg = 1'b0; end
      MOVN: begin cls = C_MOV; v = a; if (b == 0) e.wreg = 1'b0; end
      MUL:  begin cls = C_MUL; r64 = sa * sb; v = r64[31:0]; end
      MULT: begin e.whilo = 1'b1; e.wreg = 1'b0; r64 = sa * sb; {e.hi, e.lo} = r64; end
      MULTU: begin e.whilo = 1'b1; e.wreg = 1'b0; r64 = ua * ub; {e.hi, e.lo} = r64; end
      MTHI: begin e.whilo = 1'b1; e.hi = a; e.lo = hl[31:0]; end
      MTLO: begin e.whilo = 1'b1; e.hi = hl[63:32]; e.lo = a; end
      default: ;
    endcase
    if (cls != C_NOP && cls == sel) e.wdata = v;
    return e;
  endfunction

  function automatic logic [63:0] mac_prod(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    if (op == MADD || op == MSUB) p = longint'($signed(a)) * longint'($signed(b));
    else p = longint'({32'b0, a}) * longint'({32'b0, b});
    if (op == MSUB || op == MSUBU) p = -p;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    #2;
    chk({tag, ".wd"},    64'(wd_o),       64'(e.wd));
    chk({tag, ".wreg"},  64'(wreg_o),     64'(e.wreg));
    chk({tag, ".wdata"}, 64'(wdata_o),    64'(e.wdata));
    chk({tag, ".whilo"}, 64'(whilo_o),    64'(e.whilo));
    chk({tag, ".hi"},    64'(hi_o),       64'(e.hi));
    chk({tag, ".lo"},    64'(lo_o),       64'(e.lo));
    chk({tag, ".stall"}, 64'(stallreq_o), 64'(e.stall));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b;
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l, input logic mw, input logic [31:0] mh,
                          input logic ww, input logic [31:0] wh);
    hi_i = h; lo_i = l; mem_whilo_i = mw; mem_hi_i = mh; mem_lo_i = ~mh; wb_whilo_i = ww; wb_hi_i = wh; wb_lo_i = ~wh;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_hilo();
    hi_i = $urandom; lo_i = $urandom;
    mem_whilo_i = 1'($urandom_range(0, 1)); mem_hi_i = $urandom; mem_lo_i = $urandom;
    wb_whilo_i = 1'($urandom_range(0, 1));  wb_hi_i = $urandom;  wb_lo_i = $urandom;
  endtask

  initial begin
    exp_t e;
    logic [10:0] ent;
    logic [63:0] p;

    rst = 1'b1; ctrl_signal = '0; wd_i = 5'd7; wreg_i = 1'b1;
    set_op(MULT, C_NOP, 32'h1234, 32'h5678);
    set_hilo(32'h11, 32'h22, 1'b1, 32'h33, 1'b1, 32'h44);
    next_cycle();
    next_cycle();
    check_all("reset", exp_t'('0));

    rst = 1'b0;
    set_hilo(32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    set_op(ADD, C_ARI, 32'h7FFFFFFF, 32'h1);
    e = '0; e.wd = 5'd7; e.wreg = 1'b0; e.wdata = 32'h80000000;
    check_all("add_ovf", e);
    set_op(ADDU, C_ARI, 32'h7FFFFFFF, 32'h1);
    e.wreg = 1'b1;
    check_all("addu_wrap", e);

    set_op(SRA, C_SHF, 32'd4, 32'h80000000);
    e = '0; e.wd = 5'd7; e.wreg = 1'b1; e.wdata = 32'hF8000000;
    check_all("sra_fill", e);

    set_op(MFHI, C_MOV, 32'h0, 32'h0);
    set_hilo(32'd1, 32'd0, 1'b1, 32'd3, 1'b1, 32'd2);
    e.wdata = 32'd3;
    check_all("mfhi_mem", e);
    mem_whilo_i = 1'b0;
    e.wdata = 32'd2;
    check_all("mfhi_wb", e);
    wb_whilo_i = 1'b0;
    e.wdata = 32'd1;
    check_all("mfhi_arch", e);

    set_op(MULT, C_NOP, 32'hFFFFFFFE, 32'd3);
    e = '0; e.wd = 5'd7; e.whilo = 1'b1; e.hi = 32'hFFFFFFFF; e.lo = 32'hFFFFFFFA;
    check_all("mult_neg", e);
    next_cycle();

    // MADD, first cycle held by ctrl bit 4, then the normal two cycles.
    wreg_i = 1'b0;
    set_hilo(32'd1, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    set_op(MADD, C_NOP, 32'h10000, 32'h10000);
    ctrl_signal = 6'b010000;
    e = '0; e.wd = 5'd7; e.stall = 1'b1;
    check_all("madd_held", e);
    next_cycle();
    ctrl_signal = 6'b000000;
    check_all("madd_c1", e);
    next_cycle();
    e = '0; e.wd = 5'd7; e.whilo = 1'b1; e.hi = 32'd2; e.lo = 32'd0;
    check_all("madd_c2", e);
    next_cycle();

    // MSUB interrupted by reset in its second cycle, then a MULT.
    set_op(MSUB, C_NOP, 32'd5, 32'd7);
    e = '0; e.wd = 5'd7; e.stall = 1'b1;
    check_all("msub_c1", e);
    next_cycle();
    rst = 1'b1;
    check_all("msub_rst", exp_t'('0));
    next_cycle();
    rst = 1'b0;
    wreg_i = 1'b1;
    set_op(MULT, C_NOP, 32'd6, 32'd7);
    e = '0; e.wd = 5'd7; e.whilo = 1'b1; e.hi = 32'd0; e.lo = 32'd42;
    check_all("mult_after_rst", e);
    next_cycle();

    // Flushed MADDU: a different op in the second cycle writes nothing.
    set_op(MADDU, C_NOP, 32'hFFFFFFFF, 32'd2);
    e = '0; e.wd = 5'd7; e.wreg = 1'b1; e.stall = 1'b1;
    check_all("maddu_c1", e);
    next_cycle();
    set_op(MULT, C_NOP, 32'd2, 32'd2);
    e = '0; e.wd = 5'd7;
    check_all("flush_acc", e);
    next_cycle();
    e.whilo = 1'b1; e.lo = 32'd4;
    check_all("mult_after_flush", e);
    next_cycle();

    for (int it = 0; it < 300; it++) begin
      ent = op_tab[$urandom_range(0, 26)];
      aluop_i = ent[10:3];
      alusel_i = ent[2:0];
      if ($urandom_range(0, 9) == 0) begin
        aluop_i = 8'($urandom);
        alusel_i = 3'($urandom);
        if (is_mac(aluop_i)) aluop_i = NOP;
      end
      reg1_i = pick_operand();
      reg2_i = pick_operand();
      wd_i = 5'($urandom);
      wreg_i = 1'($urandom_range(0, 1));
      ctrl_signal = 6'($urandom) & 6'b101111;
      rand_hilo();
      e = model(aluop_i, alusel_i, wd_i, wreg_i, reg1_i, reg2_i, fwd_hilo());
      if (is_mac(aluop_i)) begin
        p = mac_prod(aluop_i, reg1_i, reg2_i);
        e.stall = 1'b1;
        check_all($sformatf("rnd%0d_mac1", it), e);
        next_cycle();
        rand_hilo();
        e.stall = 1'b0;
        e.whilo = 1'b1;
        {e.hi, e.lo} = fwd_hilo() + p;
        check_all($sformatf("rnd%0d_mac2", it), e);
      end else begin
        check_all($sformatf("rnd%0d_op%02h", it, aluop_i), e);
      end
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
